modexp_engine: RTL and testbench

//  Sequential 8-bit modular exponentiation unit: result = base^exponent mod modulus.

---
 rtl/modexp_engine.sv | 168 ++++++++++++++++
 tb/tb_modexp_engine.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/modexp_engine.sv
// Sequential 8-bit modular exponentiation (base^exponent mod modulus) using square-and-multiply.
// Define MODEXP_SKIPZERO_EN to skip the multiply step for zero exponent bits (data-dependent timing).

module wallace_mul8 (
  input  logic [7:0]  i_a,
  input  logic [7:0]  i_b,
  output logic [15:0] o_p
);
  logic [15:0] w_pp [8];
  logic [15:0] w_s, w_c, w_t;

  // Partial products are folded through 3:2 compressors; one carry-propagate add at the end.
  always_comb begin
    for (int j = 0; j < 8; j++) w_pp[j] = i_b[j] ? ({8'h00, i_a} << j) : 16'h0000;
    w_s = w_pp[0];
    w_c = w_pp[1];
    w_t = 16'h0000;
    for (int j = 2; j < 8; j++) begin
      w_t = w_s ^ w_c ^ w_pp[j];
      w_c = ((w_s & w_c) | (w_s & w_pp[j]) | (w_c & w_pp[j])) << 1;
      w_s = w_t;
    end
    o_p = w_s + w_c;
  end
endmodule

module modexp_engine (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] base,
  input  logic [7:0] exponent,
  input  logic [7:0] modulus,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] result
);
  typedef enum logic [1:0] {IDLE, MUL, RED, FIN} state_t;
  typedef enum logic [1:0] {PH_PRE, PH_SQ, PH_ML} phase_t;

  state_t      r_state, w_next;
  phase_t      r_phase;
  logic [7:0]  r_base, r_base_r, r_exp, r_mod, r_acc, r_rem, r_result;
  logic [15:0] r_prod;
  logic [3:0]  r_k;
  logic [2:0]  r_i;
  logic        r_err;

  logic [7:0]  w_x, w_y;
  logic [15:0] w_prod;
  logic [8:0]  w_t, w_diff;
  logic [7:0]  w_rem_n;
  logic        w_bit, w_skip, w_to_fin;

  assign w_bit = r_exp[r_i];
`ifdef MODEXP_SKIPZERO_EN
  assign w_skip = (r_phase == PH_SQ) && !w_bit;
`else
  assign w_skip = 1'b0;
`endif
  assign w_to_fin = ((r_phase == PH_ML) || w_skip) && (r_i == 3'd0);

  // ML always multiplies (by 1 for a zero bit) so the schedule stays operand-independent.
  always_comb begin
    w_x = r_acc;
    w_y = r_acc;
    case (r_phase)
      PH_PRE:  begin w_x = r_base; w_y = 8'd1; end
      PH_ML:   w_y = w_bit ? r_base_r : 8'd1;
      default: ;
    endcase
  end

  wallace_mul8 u_mul (.i_a(w_x), .i_b(w_y), .o_p(w_prod));

  // One restoring-division step; rem < m keeps t - m within 8 bits.
  assign w_t     = {r_rem, r_prod[r_k]};
  assign w_diff  = w_t - {1'b0, r_mod};
  assign w_rem_n = (w_t >= {1'b0, r_mod}) ? w_diff[7:0] : w_t[7:0];

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (start) w_next = (modulus == 8'd0) ? FIN : MUL;
      MUL:  w_next = RED;
      RED:  if (r_k == 4'd0) w_next = w_to_fin ? FIN : MUL;
      FIN:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy   = (r_state == MUL) || (r_state == RED);
    done   = (r_state == FIN);
    err    = r_err;
    result = r_result;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase  <= PH_PRE;
      r_base   <= 8'd0;
      r_base_r <= 8'd0;
      r_exp    <= 8'd0;
      r_mod    <= 8'd0;
      r_acc    <= 8'd0;
      r_rem    <= 8'd0;
      r_result <= 8'd0;
      r_prod   <= 16'd0;
      r_k      <= 4'd0;
      r_i      <= 3'd0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_base  <= base;
          r_exp   <= exponent;
          r_mod   <= modulus;
          r_acc   <= 8'd1;
          r_i     <= 3'd7;
          r_phase <= PH_PRE;
          r_err   <= (modulus == 8'd0);
          if (modulus == 8'd0) r_result <= 8'd0;
        end
        MUL: begin
          r_prod <= w_prod;
          r_rem  <= 8'd0;
          r_k    <= 4'd15;
        end
        RED: begin
          r_rem <= w_rem_n;
          r_k   <= r_k - 4'd1;
          if (r_k == 4'd0) begin
            case (r_phase)
              PH_PRE: begin
                r_base_r <= w_rem_n;
                r_phase  <= PH_SQ;
              end
              PH_SQ: begin
                r_acc <= w_rem_n;
                if (!w_skip)            r_phase  <= PH_ML;
                else if (r_i == 3'd0)   r_result <= w_rem_n;
                else                    r_i      <= r_i - 3'd1;
              end
              default: begin
                r_acc <= w_rem_n;
                if (r_i == 3'd0) r_result <= w_rem_n;
                else begin
                  r_i     <= r_i - 3'd1;
                  r_phase <= PH_SQ;
                end
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_modexp_engine.sv
// Directed and model-checked bench for modexp_engine; honours MODEXP_SKIPZERO_EN for busy length.
module tb_modexp_engine;
  logic       clk, rst, start;
  logic [7:0] base, exponent, modulus;
  logic       busy, done, err;
  logic [7:0] result;
  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  modexp_engine dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .exponent(exponent),
    .modulus(modulus), .busy(busy), .done(done), .err(err), .result(result)
  );

  function automatic int exp_busy(input logic [7:0] e);
    int pc = 0;
    for (int j = 0; j < 8; j++) pc += int'(e[j]);
`ifdef MODEXP_SKIPZERO_EN
    return 17 + 17 * pc + 8 * 17;
`else
    pc = 0;
    return 289 + pc;
`endif
  endfunction

  function automatic logic [7:0] powmod(input int b, input int e, input int m);
    int r = 1 % m;
    for (int j = 0; j < e; j++) r = (r * b) % m;
    return 8'(r);
  endfunction

  // Issue one start, then sample on falling edges until done (bounded).
  task automatic run(input logic [7:0] b, e, m, input bit pulse,
                     output logic [7:0] res, output logic er, output int bn, output bit got);
    int cyc = 0;
    bn = 0; got = 0; res = 8'hxx; er = 1'bx;
    @(negedge clk);
    base = b; exponent = e; modulus = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!got && cyc < 1000) begin
      if (busy) bn++;
      if (done) begin
        got = 1; res = result; er = err;
      end else begin
        @(negedge clk);
        cyc++;
        if (pulse && (cyc == 5 || cyc == 50)) begin
          start = 1'b1; base = 8'd11; exponent = 8'd200; modulus = 8'd0;
        end else start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    start = 1'b0; base = 8'd0; exponent = 8'd0; modulus = 8'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (err !== 1'b0)    begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL reset_result: got %0d want 0", result); end
  endtask

  task automatic test_basic();
    logic [7:0] r; logic e; int bn; bit got;
    run(8'd3, 8'd5, 8'd7, 1'b0, r, e, bn, got);
    checks++; if (!got) begin errors++; $display("FAIL basic_done: timeout"); end
    checks++; if (r !== 8'd5) begin errors++; $display("FAIL basic_result: got %0d want 5", r); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", e); end
    checks++; if (bn != exp_busy(8'd5)) begin errors++; $display("FAIL basic_busy: got %0d want %0d", bn, exp_busy(8'd5)); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got %b want 0", done); end
    checks++; if (result !== 8'd5) begin errors++; $display("FAIL result_hold: got %0d want 5", result); end
  endtask

  task automatic test_boundaries();
    logic [7:0] vb [7] = '{8'd200, 8'd9, 8'd255, 8'd2,   8'd77,  8'd0, 8'd5};
    logic [7:0] ve [7] = '{8'd1,   8'd0, 8'd2,   8'd8,   8'd123, 8'd255, 8'd3};
    logic [7:0] vm [7] = '{8'd13,  8'd5, 8'd254, 8'd255, 8'd1,   8'd9, 8'd13};
    logic [7:0] vr [7] = '{8'd5,   8'd1, 8'd1,   8'd1,   8'd0,   8'd0, 8'd8};
    logic [7:0] r; logic e; int bn; bit got;
    for (int n = 0; n < 7; n++) begin
      run(vb[n], ve[n], vm[n], 1'b0, r, e, bn, got);
      checks++;
      if (!got || r !== vr[n] || e !== 1'b0)
        begin errors++; $display("FAIL boundary_%0d: got result %0d err %b done %0d want result %0d err 0", n, r, e, got, vr[n]); end
      checks++;
      if (bn != exp_busy(ve[n]))
        begin errors++; $display("FAIL boundary_busy_%0d: got %0d want %0d", n, bn, exp_busy(ve[n])); end
    end
  endtask

  task automatic test_mod_zero();
    logic [7:0] r; logic e; int bn; bit got;
    run(8'd3, 8'd5, 8'd0, 1'b0, r, e, bn, got);
    checks++; if (!got || bn != 0) begin errors++; $display("FAIL modzero_latency: done %0d busy %0d want done with busy 0", got, bn); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL modzero_err: got %b want 1", e); end
    checks++; if (r !== 8'd0) begin errors++; $display("FAIL modzero_result: got %0d want 0", r); end
    run(8'd3, 8'd5, 8'd7, 1'b0, r, e, bn, got);
    checks++; if (e !== 1'b0 || r !== 8'd5) begin errors++; $display("FAIL modzero_clear: got err %b result %0d want err 0 result 5", e, r); end
  endtask

  task automatic test_ignore_start();
    logic [7:0] r; logic e; int bn; bit got;
    run(8'd5, 8'd3, 8'd13, 1'b1, r, e, bn, got);
    checks++; if (!got || r !== 8'd8 || e !== 1'b0) begin errors++; $display("FAIL busy_start_result: got %0d err %b want 8 err 0", r, e); end
    checks++; if (bn != exp_busy(8'd3)) begin errors++; $display("FAIL busy_start_len: got %0d want %0d", bn, exp_busy(8'd3)); end
    // Still in the FIN cycle here: a start now must not be accepted.
    start = 1'b1; base = 8'd3; exponent = 8'd5; modulus = 8'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fin_start_ignored: busy %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] r; logic e; int bn; bit got; bit saw_done = 0;
    @(negedge clk);
    base = 8'd3; exponent = 8'd5; modulus = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || result !== 8'd0)
      begin errors++; $display("FAIL mid_reset_outputs: busy %b done %b err %b result %0d want all 0", busy, done, err, result); end
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    checks++; if (saw_done) begin errors++; $display("FAIL mid_reset_abort: activity after reset, want none"); end
    run(8'd200, 8'd1, 8'd13, 1'b0, r, e, bn, got);
    checks++; if (!got || r !== 8'd5 || e !== 1'b0) begin errors++; $display("FAIL post_reset_run: got %0d err %b want 5 err 0", r, e); end
  endtask

  task automatic test_random();
    logic [7:0] b, x, m, r, want; logic e; int bn; bit got;
    for (int n = 0; n < 12; n++) begin
      b = 8'($urandom_range(0, 255));
      x = 8'($urandom_range(0, 255));
      m = 8'($urandom_range(1, 255));
      want = powmod(int'(b), int'(x), int'(m));
      run(b, x, m, 1'b0, r, e, bn, got);
      checks++;
      if (!got || r !== want || e !== 1'b0)
        begin errors++; $display("FAIL random_%0d: %0d^%0d mod %0d got %0d err %b want %0d", n, b, x, m, r, e, want); end
      checks++;
      if (bn != exp_busy(x))
        begin errors++; $display("FAIL random_busy_%0d: got %0d want %0d", n, bn, exp_busy(x)); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_mod_zero();
    test_ignore_start();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
